// File: rtl/issue_buffer_ctrl_pkg.sv
// Shared sizing defaults for the adder issue buffer; other issue units
// instantiate issue_buffer_ctrl with their own DW/DP values.
package issue_buffer_ctrl_pkg;

   localparam int ADDER_ISSUE_INFO_DW = 8;
   localparam int ADDER_ISSUE_INFO_DP = 4;

endpackage

// File: rtl/issue_buffer_ctrl_lzp.sv
// Lowest-zero priority encoder: returns the lowest index whose bit is clear,
// and flags when every bit is set.
module issue_buffer_ctrl_lzp
   import issue_buffer_ctrl_pkg::*;
#(
   parameter int N  = ADDER_ISSUE_INFO_DP,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_in,
   output logic [IW-1:0] o_idx,
   output logic          o_all1
);

   // Scan from the top down so the lowest clear bit is the last one written.
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!i_in[i]) o_idx = IW'(i);
      end
   end

   assign o_all1 = &i_in;

endmodule

// File: rtl/issue_buffer_ctrl.sv
// Reservation-station slot store for one issue unit: pushes into the lowest
// free slot, frees popped slots, and clears all allocations on flush.
module issue_buffer_ctrl
   import issue_buffer_ctrl_pkg::*;
#(
   parameter int DW = ADDER_ISSUE_INFO_DW,
   parameter int DP = ADDER_ISSUE_INFO_DP
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   dispatch_push,
   input  logic [DW-1:0]          dispatch_info,
   output logic                   buffer_full,
   output logic                   buffer_empty,
   output logic [$clog2(DP):0]    buffer_count,
   input  logic                   issue_pop,
   input  logic [$clog2(DP)-1:0]  issue_pop_index,
   output logic [DP-1:0]          buffer_malloc,
   output logic [DW*DP-1:0]       issue_info,
   input  logic                   flush
);

   localparam int IW = $clog2(DP);
   localparam int CW = $clog2(DP) + 1;

   logic [DP-1:0] r_malloc;
   logic [DW-1:0] r_info [DP];

   logic [IW-1:0] w_free_idx;
   logic          w_all1;
   logic          w_push_ok;
   logic [DP-1:0] w_set;
   logic [DP-1:0] w_clr;
   logic [CW-1:0] w_count;

   issue_buffer_ctrl_lzp #(.N(DP), .IW(IW)) u_lzp (
      .i_in   (r_malloc),
      .o_idx  (w_free_idx),
      .o_all1 (w_all1)
   );

   // Slot selection and the full check both use pre-pop state, so a slot
   // freed this cycle is never reused in the same cycle.
   assign w_push_ok = dispatch_push && !w_all1 && !flush;

   for (genvar gi = 0; gi < DP; gi++) begin : g_slot
      assign w_set[gi] = w_push_ok && (w_free_idx == IW'(gi));
      assign w_clr[gi] = issue_pop && !flush && r_malloc[gi] &&
                         (issue_pop_index == IW'(gi));

      always_ff @(posedge CLK or negedge RSTn) begin
         if (!RSTn) begin
            r_malloc[gi] <= 1'b0;
            r_info[gi]   <= '0;
         end else begin
            if (flush)          r_malloc[gi] <= 1'b0;
            else if (w_set[gi]) r_malloc[gi] <= 1'b1;
            else if (w_clr[gi]) r_malloc[gi] <= 1'b0;
            if (w_set[gi])      r_info[gi]   <= dispatch_info;
         end
      end

      assign issue_info[DW*gi +: DW] = r_info[gi];
   end

   always_comb begin
      w_count = '0;
      for (int i = 0; i < DP; i++) begin
         w_count = w_count + CW'(r_malloc[i]);
      end
   end

   assign buffer_malloc = r_malloc;
   assign buffer_count  = w_count;
   assign buffer_full   = w_all1;
   assign buffer_empty  = ~|r_malloc;

endmodule

// File: tb/tb_issue_buffer_ctrl.sv
// Directed, table-driven bench for issue_buffer_ctrl with DW=8, DP=4.
module tb_issue_buffer_ctrl;

   localparam int DW = 8;
   localparam int DP = 4;

   logic          CLK;
   logic          RSTn;
   logic          dispatch_push;
   logic [DW-1:0] dispatch_info;
   logic          buffer_full;
   logic          buffer_empty;
   logic [2:0]    buffer_count;
   logic          issue_pop;
   logic [1:0]    issue_pop_index;
   logic [DP-1:0] buffer_malloc;
   logic [DW*DP-1:0] issue_info;
   logic          flush;

   issue_buffer_ctrl #(.DW(DW), .DP(DP)) dut (
      .CLK             (CLK),
      .RSTn            (RSTn),
      .dispatch_push   (dispatch_push),
      .dispatch_info   (dispatch_info),
      .buffer_full     (buffer_full),
      .buffer_empty    (buffer_empty),
      .buffer_count    (buffer_count),
      .issue_pop       (issue_pop),
      .issue_pop_index (issue_pop_index),
      .buffer_malloc   (buffer_malloc),
      .issue_info      (issue_info),
      .flush           (flush)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       push;
      logic [7:0] info;
      logic       pop;
      logic [1:0] idx;
      logic       fl;
      logic [3:0] exp_malloc;
      logic [2:0] exp_count;
      logic       exp_full;
      logic       exp_empty;
      int         chk_slot;   // -1: no info check
      logic [7:0] exp_info;
   } vec_t;

   vec_t vecs [17];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] slot_info(input int s);
      logic [DW*DP-1:0] v;
      v = issue_info;
      return v[DW*s +: DW];
   endfunction

   initial begin
      //           push info   pop idx fl  malloc  cnt full empty slot info
      vecs[0]  = '{1, 8'hA1, 0, 0, 0, 4'b0001, 1, 0, 0,  0, 8'hA1};
      vecs[1]  = '{1, 8'hB2, 0, 0, 0, 4'b0011, 2, 0, 0,  1, 8'hB2};
      vecs[2]  = '{1, 8'hC3, 0, 0, 0, 4'b0111, 3, 0, 0,  2, 8'hC3};
      vecs[3]  = '{1, 8'hD4, 0, 0, 0, 4'b1111, 4, 1, 0,  3, 8'hD4};
      vecs[4]  = '{1, 8'h55, 0, 0, 0, 4'b1111, 4, 1, 0,  0, 8'hA1}; // push while full
      vecs[5]  = '{1, 8'hE5, 1, 1, 0, 4'b1101, 3, 0, 0,  1, 8'hB2}; // pop+push when full
      vecs[6]  = '{1, 8'hE5, 0, 0, 0, 4'b1111, 4, 1, 0,  1, 8'hE5};
      vecs[7]  = '{0, 8'h00, 1, 3, 0, 4'b0111, 3, 0, 0, -1, 8'h00};
      vecs[8]  = '{0, 8'h00, 1, 1, 0, 4'b0101, 2, 0, 0, -1, 8'h00};
      vecs[9]  = '{1, 8'hF6, 1, 0, 0, 4'b0110, 2, 0, 0,  1, 8'hF6}; // push avoids freed slot 0
      vecs[10] = '{1, 8'h17, 0, 0, 0, 4'b0111, 3, 0, 0,  0, 8'h17};
      vecs[11] = '{1, 8'h28, 0, 0, 0, 4'b1111, 4, 1, 0,  3, 8'h28};
      vecs[12] = '{0, 8'h00, 1, 2, 0, 4'b1011, 3, 0, 0, -1, 8'h00};
      vecs[13] = '{1, 8'h99, 1, 3, 1, 4'b0000, 0, 0, 1,  2, 8'hC3}; // flush wins
      vecs[14] = '{0, 8'h00, 1, 2, 0, 4'b0000, 0, 0, 1, -1, 8'h00}; // pop of free slot
      vecs[15] = '{1, 8'h3A, 0, 0, 0, 4'b0001, 1, 0, 0,  0, 8'h3A};
      vecs[16] = '{1, 8'h4B, 1, 2, 0, 4'b0011, 2, 0, 0,  1, 8'h4B}; // pop of free slot w/ push

      RSTn = 1'b0;
      dispatch_push = 0; dispatch_info = '0; issue_pop = 0; issue_pop_index = '0; flush = 0;
      repeat (2) @(negedge CLK);
      check("rst_malloc", 32'(buffer_malloc), 0);
      check("rst_info",   32'(issue_info), 0);
      check("rst_count",  32'(buffer_count), 0);
      check("rst_full",   32'(buffer_full), 0);
      check("rst_empty",  32'(buffer_empty), 1);
      RSTn = 1'b1;
      @(negedge CLK);
      check("rel_malloc", 32'(buffer_malloc), 0);
      check("rel_empty",  32'(buffer_empty), 1);
      $display("reset: malloc=%b count=%0d empty=%b", buffer_malloc, buffer_count, buffer_empty);

      for (int i = 0; i < 17; i++) begin
         dispatch_push   = vecs[i].push;
         dispatch_info   = vecs[i].info;
         issue_pop       = vecs[i].pop;
         issue_pop_index = vecs[i].idx;
         flush           = vecs[i].fl;
         @(negedge CLK);
         check($sformatf("v%0d_malloc", i), 32'(buffer_malloc), 32'(vecs[i].exp_malloc));
         check($sformatf("v%0d_count", i),  32'(buffer_count),  32'(vecs[i].exp_count));
         check($sformatf("v%0d_full", i),   32'(buffer_full),   32'(vecs[i].exp_full));
         check($sformatf("v%0d_empty", i),  32'(buffer_empty),  32'(vecs[i].exp_empty));
         if (vecs[i].chk_slot >= 0)
            check($sformatf("v%0d_info", i), 32'(slot_info(vecs[i].chk_slot)), 32'(vecs[i].exp_info));
         $display("vec %0d: push=%b info=%h pop=%b idx=%0d flush=%b -> malloc=%b count=%0d full=%b empty=%b",
                  i, vecs[i].push, vecs[i].info, vecs[i].pop, vecs[i].idx, vecs[i].fl,
                  buffer_malloc, buffer_count, buffer_full, buffer_empty);
      end

      // Build malloc=0111, then assert reset between clock edges.
      dispatch_push = 1; dispatch_info = 8'h5C; issue_pop = 0; flush = 0;
      @(negedge CLK);
      dispatch_push = 0;
      check("mid_pre_malloc", 32'(buffer_malloc), 32'(4'b0111));
      #2 RSTn = 1'b0;
      #1;
      check("mid_malloc", 32'(buffer_malloc), 0);
      check("mid_count",  32'(buffer_count), 0);
      check("mid_empty",  32'(buffer_empty), 1);
      check("mid_info",   32'(issue_info), 0);
      $display("async reset mid-stream: malloc=%b count=%0d empty=%b", buffer_malloc, buffer_count, buffer_empty);
      @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
      check("post_rst_empty", 32'(buffer_empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/issue_buffer_ctrl.md
Name: issue_buffer_ctrl

Overview:
- Holds the reservation-station entries that feed one issue unit, such as the adder issue stage.
- Accepts one dispatched micro-op per cycle into the lowest-index free slot.
- Exposes every slot's info and a per-slot allocation bitmap to the issue stage.
- Frees the slot the issue stage pops, and flushes every slot on a pipeline flush.

Parameters:
- DW, `ADDER_ISSUE_INFO_DW: width of one slot's issue info.
- DP, `ADDER_ISSUE_INFO_DP: number of slots; a power of 2, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- dispatch_push  in  1  write dispatch_info into a free slot this cycle.
- dispatch_info  in  DW  issue info to store.
- buffer_full  out  1  every slot is allocated; dispatch must not push.
- buffer_empty  out  1  no slot is allocated.
- buffer_count  out  $clog2(DP)+1  number of allocated slots.
- issue_pop  in  1  the issue stage takes the slot at issue_pop_index.
- issue_pop_index  in  $clog2(DP)  index of the slot being popped.
- buffer_malloc  out  DP  allocated bit, one per slot.
- issue_info  out  DW*DP  slot i occupies bits [DW*i +: DW].
- flush  in  1  clears all slots (mispredict or exception).

Behaviour:
- Reset (asynchronous, RSTn=0):
  - buffer_malloc=0, issue_info=0, buffer_count=0.
  - buffer_full=0, buffer_empty=1.
  - Registers are gen_dffr style; releasing reset mid-operation leaves the buffer empty.
- Storage: DP registered slots of DW bits each, plus a DP-bit malloc register. All outputs are derived from registers; there is no combinational path from inputs to outputs.
- Push:
  - Free slot index = the lowest i where malloc_qout[i]=0, judged on the registered malloc value.
  - When dispatch_push=1 and buffer_full=0, the selected slot loads dispatch_info and its malloc bit sets.
  - Both become visible at the next edge (latency 1).
- Push when full: ignored, with no state change. The bench flags it as a protocol error.
- Pop:
  - When issue_pop=1 and malloc_qout[issue_pop_index]=1, that slot's malloc bit clears at the next edge.
  - The slot's info is not cleared; stale info is don't-care.
- Pop of an unallocated index: ignored. The bench flags it as an error.
- Push and pop in the same cycle:
  - Both take effect.
  - The push never lands in the slot freed that cycle, because free-slot selection uses the pre-pop malloc.
  - When full, a pop does not enable a same-cycle push; buffer_full is a registered-state view.
- Flush:
  - Highest priority: malloc becomes 0 at the next edge, and any push or pop that cycle is discarded.
  - Info registers keep their contents.
- buffer_count:
  - Computed as the population count of malloc_qout.
  - buffer_full = &malloc_qout; buffer_empty = ~|malloc_qout.
- Ordering:
  - Slot index does not imply age.
  - The issue stage picks the lowest-index ready slot, which is the existing policy.
- Width rule: buffer_count is $clog2(DP)+1 bits so that DP itself is representable.

Decomposition:
- Macros `ADDER_ISSUE_INFO_DW and `ADDER_ISSUE_INFO_DP stay in define.vh. Other issue units instantiate the block with their own DW/DP macros.
- Free-slot search reuses the existing lzp priority encoder, with in_i = malloc_qout and all1 giving full.
- Per-slot storage uses gen_dffr with an enable mux. No new sub-module is created.

Test Plan (DP=4):
- Reset then release → malloc=4'b0000, buffer_empty=1, buffer_count=0, buffer_full=0.
- Push A, B, C, D on four consecutive cycles → malloc goes 0001, 0011, 0111, 1111; buffer_full=1; slot 2 info = C.
- From malloc=1111: pop index 1 together with a push of E → malloc=1101 and E is not written. Next cycle push E → slot 1 = E, malloc=1111.
- From malloc=0101: pop index 0 together with a push of F → F goes to slot 1, malloc=0110, buffer_count=2.
- From malloc=1011: flush asserted together with a push and a pop of index 3 → malloc=0000, buffer_empty=1, no write.
- Assert RSTn=0 mid-stream with malloc=0111 → outputs go to reset values immediately, without waiting for a clock edge.
